// File: rtl/galois_lfsr_checker.sv
// Receive-side checker for the 8-bit Galois LFSR pattern (x^8+x^4+x^3+x^2+1).
// Self-synchronises to the incoming stream, declares lock, then counts bit
// errors against the locally predicted sequence.
//
// Optional build macro: GALOIS_LFSR_CHECKER_BER_EN
//   defined   : bit_count accumulates compared bits while locked (for BER).
//   undefined : bit_count is tied to zero and no counter is built.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_SEARCH | history fed from received bits; fill, then count clean beats
// ST_LOCKED | history fed from predicted bits; count errors, watch for loss
module galois_lfsr_checker #(
    parameter int IN_BITS    = 1,
    parameter int LOCK_COUNT = 16,
    parameter int LOSS_COUNT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [IN_BITS-1:0] in_data,
    input  logic               clear_count,
    output logic               locked,
    output logic               bit_error,
    output logic [15:0]        error_count,
    output logic [31:0]        bit_count
);

    if (IN_BITS < 1 || IN_BITS > 4) begin : g_bad_in_bits
        $error("galois_lfsr_checker: IN_BITS must be in 1..4");
    end

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Beats needed before the history holds 8 received bits.
    localparam int FILL_BEATS = (8 + IN_BITS - 1) / IN_BITS;
    localparam int FILL_W     = $clog2(FILL_BEATS + 1);
    localparam int MR_W       = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
    localparam int LR_W       = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT + 1) : 1;

    logic [0:0]        state;
    logic [7:0]        history;     // [0] = s[n-1] ... [7] = s[n-8]
    logic [FILL_W-1:0] fill_cnt;
    logic [MR_W-1:0]   match_run;
    logic [LR_W-1:0]   loss_run;

    logic [7:0]        hist_nxt;
    logic [2:0]        beat_miss;
    logic              zero_seen;
    logic              beat_errored;
    logic              count_en;
    logic [16:0]       err_sum;

    // Walk the beat oldest-bit first; each prediction sees the history as
    // already advanced by the earlier bits of the same beat.
    always_comb begin
        logic [7:0] h;
        logic       pred;
        h         = history;
        pred      = 1'b0;
        beat_miss = 3'd0;
        zero_seen = 1'b0;
        for (int i = IN_BITS - 1; i >= 0; i--) begin
            if (h == 8'h00) begin
                zero_seen = 1'b1;
            end
            pred      = h[3] ^ h[4] ^ h[5] ^ h[7];
            beat_miss = beat_miss + {2'b00, pred ^ in_data[i]};
            h         = {h[6:0], (state == ST_LOCKED) ? pred : in_data[i]};
        end
        hist_nxt = h;
    end

    assign beat_errored = (beat_miss != 3'd0);
    assign count_en     = in_valid && (state == ST_LOCKED);
    assign err_sum      = {1'b0, error_count} + {14'd0, beat_miss};
    assign locked       = (state == ST_LOCKED);

    // Synchronisation FSM: fill, match-run qualification, loss detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_SEARCH;
            history   <= 8'h00;
            fill_cnt  <= '0;
            match_run <= '0;
            loss_run  <= '0;
        end else if (in_valid) begin
            history <= hist_nxt;
            case (state)
                ST_SEARCH: begin
                    if (fill_cnt != FILL_W'(FILL_BEATS)) begin
                        fill_cnt <= fill_cnt + FILL_W'(1);
                    end else if (beat_errored || zero_seen) begin
                        // An all-zero history would "predict" a stuck-at-0
                        // line perfectly, so it never counts as a match.
                        match_run <= '0;
                    end else if (match_run == MR_W'(LOCK_COUNT - 1)) begin
                        state     <= ST_LOCKED;
                        match_run <= '0;
                        loss_run  <= '0;
                    end else begin
                        match_run <= match_run + MR_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (beat_errored) begin
                        if (loss_run == LR_W'(LOSS_COUNT - 1)) begin
                            state     <= ST_SEARCH;
                            fill_cnt  <= '0;
                            match_run <= '0;
                            loss_run  <= '0;
                        end else begin
                            loss_run <= loss_run + LR_W'(1);
                        end
                    end else begin
                        loss_run <= '0;
                    end
                end
                default: begin
                    state <= ST_SEARCH;
                end
            endcase
        end
    end

    // One-cycle flag for any mismatched bit in a locked beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_error <= 1'b0;
        end else begin
            bit_error <= count_en && beat_errored;
        end
    end

    // Saturating error counter; a clear discards the same-cycle beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_count <= 16'h0000;
        end else if (clear_count) begin
            error_count <= 16'h0000;
        end else if (count_en) begin
            error_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

`ifdef GALOIS_LFSR_CHECKER_BER_EN
    logic [32:0] bit_sum;
    assign bit_sum = {1'b0, bit_count} + 33'(IN_BITS);

    // Saturating count of compared bits while locked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_count <= 32'h0000_0000;
        end else if (clear_count) begin
            bit_count <= 32'h0000_0000;
        end else if (count_en) begin
            bit_count <= bit_sum[32] ? 32'hFFFF_FFFF : bit_sum[31:0];
        end
    end
`else
    assign bit_count = 32'h0000_0000;
`endif

endmodule
